fifo_wptr_full: RTL and testbench
=================================

// Module: fifo_wptr_full
// PURPOSE
//  Write-side pointer and flag generator for the asynchronous FIFO; the encoding end of the Gray pointer path.
//  Keeps the binary write pointer and drives the RAM write address.
//  Publishes a registered Gray-coded write pointer for the read-domain synchroniser.
//  Derives full, almost_full and fill level from the read pointer, which arrives already synchronised into this domain.
// PARAMETERS
//  ADDR_WIDTH   4   RAM address bits; DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits; legal range >= 2
//  AFULL_THRESH 12  almost_full asserts when level >= AFULL_THRESH; legal range 1..DEPTH
// PORTS
//  wclk            in   1             write-domain clock
//  wrst            in   1             asynchronous, active-high reset
//  wr_en           in   1             write request
//  rptr_gray_sync  in   ADDR_WIDTH+1  read pointer (Gray), already 2-FF synchronised to wclk
//  waddr           out  ADDR_WIDTH    RAM write address; = wbin[ADDR_WIDTH-1:0]
//  wptr_gray       out  ADDR_WIDTH+1  registered Gray write pointer, to read-domain synchroniser
//  full            out  1             registered; FIFO holds DEPTH entries
//  almost_full     out  1             registered; level >= AFULL_THRESH
//  level           out  ADDR_WIDTH+1  registered fill level, 0..DEPTH
//  wr_ack          out  1             1-cycle pulse: write accepted on previous edge
//  wr_overflow     out  1             1-cycle pulse: write rejected because full
// BEHAVIOUR
//  - One clock (wclk). Reset is asynchronous and active-high (wrst).
//  - Reset: wbin, wptr_gray, waddr, level, full, almost_full, wr_ack and wr_overflow all 0, immediately and without a clock edge.
//  - Accept: wr_inc = wr_en & ~full.
//      wbin_next  = wbin + wr_inc, modulo 2**(ADDR_WIDTH+1).
//      wgray_next = wbin_next ^ (wbin_next >> 1).
//  - Every edge: wbin <= wbin_next and wptr_gray <= wgray_next.
//      wptr_gray comes only from a flop, never from combinational logic.
//      wptr_gray changes by exactly one bit per accepted write, including across the wrap 2**(ADDR_WIDTH+1)-1 -> 0.
//  - RAM writes at the accepting edge, using the pre-increment waddr. Write-to-pointer-update latency is 1 cycle.
//  - Full: full <= (wgray_next == {~rptr_gray_sync[MSB:MSB-1], rptr_gray_sync[MSB-2:0]}), where MSB = ADDR_WIDTH.
//      It is recomputed every edge, so full clears on the first edge after rptr_gray_sync advances.
//  - Level: rbin = Gray-to-binary of rptr_gray_sync (combinational XOR prefix from the MSB).
//      level <= (wbin_next - rbin) mod 2**(ADDR_WIDTH+1), range 0..DEPTH.
//      almost_full <= (that value >= AFULL_THRESH).
//  - Pulses: wr_ack <= wr_inc. wr_overflow <= wr_en & full.
//      On overflow, wbin and wptr_gray hold and the RAM must not be written.
//  - Simultaneous write and read-pointer advance at the same edge: both are used.
//      Level changes by +1-1 = 0 and full stays 0.
//  - Because the read pointer is stale, full and level are pessimistic (never report less data than is present).
//  - Reset mid-burst: pointers return to 0 at once; the read side must be reset together with this block.
// TESTING (ADDR_WIDTH=4, AFULL_THRESH=12)
//  1. Assert wrst with no clock running -> all outputs 0 immediately; they stay 0 while wrst=1 even with wr_en=1.
//  2. rptr_gray_sync=0, 16 writes back to back:
//       wptr_gray = 00001,00011,00010,00110,...; after write 16, wptr_gray=11000, level=16, full=1.
//       almost_full rises the edge level reaches 12. wr_ack is high for 16 cycles.
//  3. While full, wr_en=1 for 3 cycles -> wr_overflow high 3 cycles, wr_ack=0, waddr/wptr_gray unchanged.
//  4. From full, set rptr_gray_sync=00001 -> next edge full=0 and level=15.
//     Assert wr_en that same cycle -> wr_ack, full=1 again, wptr_gray=11001.
//  5. Run the pointer through 40 writes with reads keeping pace:
//       check every wptr_gray step differs by exactly 1 bit, including 10000->00000 at the wrap.
//       level never exceeds 16.
//  6. Pulse wrst mid-burst at level=7 -> level, full and wptr_gray go to 0 asynchronously.
//     The first write after release gives waddr=0 and wptr_gray=00001.

Source files
------------

// File: rtl/fifo_wptr_full.sv
// fifo_wptr_full: write-side binary/Gray pointer, RAM address and full/level flags for an async FIFO
module fifo_wptr_full #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  wr_ack,
  output logic                  wr_overflow
);
  localparam int PW = ADDR_WIDTH + 1;
  logic [ADDR_WIDTH:0] wbin_q, wbin_d, wgray_q, wgray_d, rbin, level_q, level_d;
  logic full_q, full_d, afull_q, afull_d, ack_q, ovf_q, wr_inc;
  for (genvar i = 0; i <= ADDR_WIDTH; i++) begin : g_rbin
    assign rbin[i] = ^rptr_gray_sync[ADDR_WIDTH:i];
  end
  always_comb begin
    wr_inc  = wr_en & ~full_q;
    wbin_d  = wbin_q + PW'(wr_inc);
    wgray_d = wbin_d ^ (wbin_d >> 1);
    full_d  = wgray_d == {~rptr_gray_sync[ADDR_WIDTH:ADDR_WIDTH-1], rptr_gray_sync[ADDR_WIDTH-2:0]};
    level_d = wbin_d - rbin;
    afull_d = level_d >= PW'(AFULL_THRESH);
  end
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ack_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ack_q   <= wr_inc;
      ovf_q   <= wr_en & full_q;
    end
  end
  assign waddr       = wbin_q[ADDR_WIDTH-1:0];
  assign wptr_gray   = wgray_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign level       = level_q;
  assign wr_ack      = ack_q;
  assign wr_overflow = ovf_q;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// tb_fifo_wptr_full: randomized scoreboard bench for the write-side pointer/flag block
module tb_fifo_wptr_full;
  localparam int AW = 4, DEPTH = 16, AF = 12;
  logic wclk = 0, wrst = 0, wr_en = 0;
  logic [AW:0] rptr_gray_sync = '0;
  logic [AW-1:0] waddr;
  logic [AW:0] wptr_gray, level;
  logic full, almost_full, wr_ack, wr_overflow;
  typedef struct {
    logic [AW-1:0] waddr;
    logic [AW:0]   gray, level;
    logic          full, afull, ack, ovf;
  } exp_t;
  exp_t q[$];
  exp_t m;
  int checks = 0, failures = 0;
  int wc = 0, rc = 0;
  bit full_m = 0, clk_on = 0;
  logic [AW:0] prev_g = '0;

  fifo_wptr_full #(.ADDR_WIDTH(AW), .AFULL_THRESH(AF)) dut (
    .wclk(wclk), .wrst(wrst), .wr_en(wr_en), .rptr_gray_sync(rptr_gray_sync),
    .waddr(waddr), .wptr_gray(wptr_gray), .full(full), .almost_full(almost_full),
    .level(level), .wr_ack(wr_ack), .wr_overflow(wr_overflow)
  );

  always #5 if (clk_on) wclk = ~wclk;

  function automatic logic [AW:0] g(int n);
    logic [AW:0] b;
    b = n[AW:0];
    return b ^ (b >> 1);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic zero_chk(string tag);
    chk({tag, "_waddr"}, 32'(waddr), 0);
    chk({tag, "_gray"}, 32'(wptr_gray), 0);
    chk({tag, "_level"}, 32'(level), 0);
    chk({tag, "_full"}, 32'(full), 0);
    chk({tag, "_afull"}, 32'(almost_full), 0);
    chk({tag, "_ack"}, 32'(wr_ack), 0);
    chk({tag, "_ovf"}, 32'(wr_overflow), 0);
  endtask

  // Model counts writes and reads as unbounded integers; the DUT's pointers are these mod 32.
  task automatic step(bit we, bit radv);
    exp_t e;
    int lvl;
    bit acc;
    @(negedge wclk);
    wr_en = we;
    if (radv && rc < wc) rc++;
    rptr_gray_sync = g(rc);
    acc = we && !full_m;
    wc += int'(acc);
    lvl = wc - rc;
    e.waddr = wc[AW-1:0];
    e.gray  = g(wc);
    e.level = lvl[AW:0];
    e.full  = (lvl == DEPTH);
    e.afull = (lvl >= AF);
    e.ack   = acc;
    e.ovf   = we && full_m;
    full_m  = e.full;
    q.push_back(e);
    @(posedge wclk);
    #2;
  endtask

  always @(posedge wclk) begin
    #1;
    if (q.size() > 0) begin
      m = q.pop_front();
      chk("waddr", 32'(waddr), 32'(m.waddr));
      chk("wptr_gray", 32'(wptr_gray), 32'(m.gray));
      chk("level", 32'(level), 32'(m.level));
      chk("full", 32'(full), 32'(m.full));
      chk("almost_full", 32'(almost_full), 32'(m.afull));
      chk("wr_ack", 32'(wr_ack), 32'(m.ack));
      chk("wr_overflow", 32'(wr_overflow), 32'(m.ovf));
      if (wptr_gray != prev_g) chk("gray_1bit", 32'($countones(wptr_gray ^ prev_g)), 1);
      chk("level_max", 32'(level > DEPTH), 0);
    end
    prev_g = wptr_gray;
  end

  initial begin
    wr_en = 1;
    #1 wrst = 1;
    #2 zero_chk("rst_noclk");
    clk_on = 1;
    repeat (3) @(posedge wclk);
    #1 zero_chk("rst_held");
    @(negedge wclk);
    wrst = 0;
    wr_en = 0;

    repeat (16) step(1, 0);
    chk("fill_gray", 32'(wptr_gray), 32'b11000);
    chk("fill_level", 32'(level), 16);
    chk("fill_full", 32'(full), 1);

    repeat (3) step(1, 0);
    chk("ovf_waddr", 32'(waddr), 0);
    chk("ovf_gray", 32'(wptr_gray), 32'b11000);

    step(0, 1);
    chk("rd_full", 32'(full), 0);
    chk("rd_level", 32'(level), 15);
    step(1, 0);
    chk("refill_ack", 32'(wr_ack), 1);
    chk("refill_full", 32'(full), 1);
    chk("refill_gray", 32'(wptr_gray), 32'b11001);

    repeat (300) step(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 3) != 0));

    while (rc < wc) step(0, 1);
    step(0, 0);
    repeat (7) step(1, 0);
    chk("pre_rst_level", 32'(level), 7);
    #1 wrst = 1;
    wr_en = 0;
    #1;
    chk("midrst_level", 32'(level), 0);
    chk("midrst_full", 32'(full), 0);
    chk("midrst_gray", 32'(wptr_gray), 0);
    wc = 0; rc = 0; full_m = 0;
    rptr_gray_sync = '0;
    @(posedge wclk);
    @(negedge wclk);
    wrst = 0;
    chk("post_rst_waddr", 32'(waddr), 0);
    step(1, 0);
    chk("post_rst_gray", 32'(wptr_gray), 32'b00001);

    repeat (2) @(posedge wclk);
    #2;
    chk("queue_drained", 32'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
